// File: rtl/riscv_pkg.sv
// Shared RV32 fetch-path types and constants.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] PC_INC           = 32'd4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // One buffered fetch result: the word and the PC it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO with flush and simultaneous push/pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             pop_ok, push_ok;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Pop only a present entry; push only into free space (or space freed this cycle).
  always_comb begin
    pop_ok  = pop_i && (count_q != '0);
    push_ok = push_i && ((count_q != CW'(DEPTH)) || pop_ok);
  end

  // Pointer and occupancy next-state; flush empties the buffer outright.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch stage: sequential imem requests, in-order response
// buffering, redirect flush with squashing of in-flight responses.
module ifetch_queue
  import riscv_pkg::*;
#(
  parameter int unsigned     DEPTH           = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst_encoding,
  output logic [XLEN-1:0] inst_pc
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q,  resp_pc_d;
  // outstanding_q counts every granted-but-unreturned request, stale ones
  // included; discard_q is the subset of those still to be dropped.
  logic [OW-1:0]   outstanding_q, outstanding_d;
  logic [OW-1:0]   discard_q,     discard_d;

  logic [CW-1:0]   fifo_count;
  fetch_entry_t    fifo_head, fifo_in;
  logic            gnt_fire, rsp_fire, rsp_keep, pop_fire;

  // Request when room is reserved for every word that could come back.
  always_comb begin
    imem_req = !rst && !redirect_valid
               && (outstanding_q < OW'(MAX_OUTSTANDING))
               && ((32'(fifo_count) + 32'(outstanding_q)) < DEPTH);
    gnt_fire = imem_req && imem_gnt;
    rsp_fire = imem_rvalid && (outstanding_q != '0);
    rsp_keep = rsp_fire && (discard_q == '0) && !redirect_valid;
    pop_fire = inst_valid && inst_ready && !redirect_valid;
    fifo_in  = '{pc: resp_pc_q, inst: imem_rdata};
  end

  // PC and counter next-state. On redirect every request still in flight
  // (minus the one returning now) becomes stale, which matches adding the
  // live count to the pending discards.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q + OW'(gnt_fire) - OW'(rsp_fire);
    discard_d     = discard_q;
    if (redirect_valid) begin
      fetch_pc_d = word_align(redirect_pc);
      resp_pc_d  = word_align(redirect_pc);
      discard_d  = outstanding_q - OW'(rsp_fire);
    end else begin
      if (gnt_fire) fetch_pc_d = fetch_pc_q + PC_INC;
      if (rsp_keep) resp_pc_d  = resp_pc_q + PC_INC;
      if (rsp_fire && (discard_q != '0)) discard_d = discard_q - OW'(1);
    end
  end

  // Fetch-side state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid),
    .push_i  (rsp_keep),
    .data_i  (fifo_in),
    .pop_i   (pop_fire),
    .data_o  (fifo_head),
    .count_o (fifo_count)
  );

  assign imem_addr     = fetch_pc_q;
  assign inst_valid    = (fifo_count != '0);
  assign inst_encoding = inst_valid ? fifo_head.inst : '0;
  assign inst_pc       = inst_valid ? fifo_head.pc   : '0;

  // A response with nothing in flight is a memory-side protocol error.
  a_no_spurious_rsp: assert property (
    @(posedge clk) disable iff (rst) imem_rvalid |-> (outstanding_q != '0));

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized bench for ifetch_queue against a queue-based reference model.
module tb_ifetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXO  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_encoding;
  logic [31:0] inst_pc;

  always #5 clk = ~clk;

  ifetch_queue #(
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAXO),
    .RESET_PC        (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_encoding  (inst_encoding),
    .inst_pc        (inst_pc)
  );

  typedef struct { logic [31:0] addr; int unsigned due; } mreq_t;
  typedef struct { logic [31:0] addr; bit stale; }        fl_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; }  ent_t;

  mreq_t       mem_q[$];   // memory environment: granted requests awaiting return
  fl_t         m_infl[$];  // model: fetches in flight, marked stale by redirects
  ent_t        m_q[$];     // model: buffered words visible to decode
  logic [31:0] m_fetch, m_resp;
  logic [31:0] deliv[$], grants[$];
  int unsigned cyc = 0, tests_run = 0, failed = 0, max_pend = 0;
  int unsigned gnt_pct = 100, rdy_pct = 100, lat_min = 1, lat_max = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic clear_env();
    mem_q.delete(); m_infl.delete(); m_q.delete();
    m_fetch = 32'h0; m_resp = 32'h0;
    deliv.delete(); grants.delete(); max_pend = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; redirect_valid = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; inst_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    clear_env();
    rst = 1'b0;
  endtask

  // One clock: drive inputs, compare outputs to the model, advance the model.
  task automatic cycle(input bit redir, input logic [31:0] tgt);
    bit exp_req, gf, pf, rf;
    int unsigned due;
    mreq_t mr;
    fl_t f;
    @(negedge clk);
    redirect_valid = redir;
    redirect_pc    = redir ? tgt : $urandom;
    imem_gnt       = ($urandom_range(0, 99) < gnt_pct);
    inst_ready     = ($urandom_range(0, 99) < rdy_pct);
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1; imem_rdata = mem_word(mem_q[0].addr);
    end else begin
      imem_rvalid = 1'b0; imem_rdata = $urandom;
    end
    #1;
    exp_req = !redir && (m_infl.size() < MAXO) && ((m_q.size() + m_infl.size()) < DEPTH);
    tests_run++;
    if (imem_req !== exp_req) begin
      failed++; $display("FAIL imem_req cyc=%0d: got %b expected %b", cyc, imem_req, exp_req);
    end
    tests_run++;
    if (imem_addr !== m_fetch) begin
      failed++; $display("FAIL imem_addr cyc=%0d: got %h expected %h", cyc, imem_addr, m_fetch);
    end
    tests_run++;
    if (inst_valid !== (m_q.size() != 0)) begin
      failed++; $display("FAIL inst_valid cyc=%0d: got %b expected %b", cyc, inst_valid, m_q.size() != 0);
    end
    if (m_q.size() != 0) begin
      tests_run++;
      if (inst_pc !== m_q[0].pc || inst_encoding !== m_q[0].inst) begin
        failed++;
        $display("FAIL head cyc=%0d: got pc=%h enc=%h expected pc=%h enc=%h",
                 cyc, inst_pc, inst_encoding, m_q[0].pc, m_q[0].inst);
      end
    end
    gf = exp_req && imem_gnt;
    rf = imem_rvalid;
    pf = (m_q.size() != 0) && inst_ready && !redir;
    // memory environment
    if (rf) mr = mem_q.pop_front();
    if (gf) begin
      due = cyc + $urandom_range(lat_min, lat_max);
      if (mem_q.size() > 0 && mem_q[$].due > due) due = mem_q[$].due;
      mem_q.push_back('{addr: m_fetch, due: due});
    end
    if (mem_q.size() > max_pend) max_pend = mem_q.size();
    // reference model
    if (pf) begin
      deliv.push_back(m_q[0].pc);
      void'(m_q.pop_front());
    end
    if (rf && m_infl.size() > 0) begin
      f = m_infl.pop_front();
      if (!redir && !f.stale) begin
        m_q.push_back('{pc: m_resp, inst: mem_word(f.addr)});
        m_resp = m_resp + 32'd4;
      end
    end
    if (redir) begin
      m_q.delete();
      foreach (m_infl[i]) m_infl[i].stale = 1'b1;
      m_fetch = {tgt[31:2], 2'b00};
      m_resp  = {tgt[31:2], 2'b00};
    end else if (gf) begin
      grants.push_back(m_fetch);
      m_infl.push_back('{addr: m_fetch, stale: 1'b0});
      m_fetch = m_fetch + 32'd4;
    end
    cyc++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; redirect_valid = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; inst_ready = 1'b0;
    for (int unsigned k = 0; k < 2; k++) begin
      #1;
      tests_run++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b0 || imem_addr !== 32'h0 ||
          inst_encoding !== 32'h0 || inst_pc !== 32'h0) begin
        failed++;
        $display("FAIL reset_outputs: got req=%b valid=%b addr=%h enc=%h pc=%h expected 0,0,0,0,0",
                 imem_req, inst_valid, imem_addr, inst_encoding, inst_pc);
      end
      @(negedge clk);
    end
    clear_env();
    rst = 1'b0;
    gnt_pct = 0; rdy_pct = 0;
    cycle(1'b0, '0);
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failed++; $display("FAIL first_req: got req=%b addr=%h expected 1 00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_stream();
    do_reset();
    gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1;
    for (int unsigned k = 0; k < 20; k++) cycle(1'b0, '0);
    tests_run++;
    if (deliv.size() != 18) begin
      failed++; $display("FAIL stream_rate: got %0d deliveries expected 18", deliv.size());
    end
    foreach (deliv[i]) begin
      tests_run++;
      if (deliv[i] !== 32'(i) * 32'd4) begin
        failed++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, deliv[i], 32'(i) * 32'd4);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc;
    do_reset();
    gnt_pct = 100; rdy_pct = 0; lat_min = 1; lat_max = 1;
    for (int unsigned k = 0; k < 12; k++) cycle(1'b0, '0);
    tests_run++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== 32'h0 || m_q.size() != DEPTH) begin
      failed++;
      $display("FAIL bp_hold: got req=%b valid=%b pc=%h held=%0d expected 0 1 00000000 4",
               imem_req, inst_valid, inst_pc, m_q.size());
    end
    rdy_pct = 100;
    for (int unsigned k = 0; k < 10; k++) cycle(1'b0, '0);
    for (int unsigned i = 0; i < 5; i++) begin
      exp_pc = 32'(i) * 32'd4;
      tests_run++;
      if (i >= deliv.size() || deliv[i] !== exp_pc) begin
        failed++;
        $display("FAIL bp_order[%0d]: got %h expected %h", i, (i < deliv.size()) ? deliv[i] : 32'hx, exp_pc);
      end
    end
  endtask

  task automatic test_latency();
    do_reset();
    gnt_pct = 100; rdy_pct = 100; lat_min = 3; lat_max = 3;
    for (int unsigned k = 0; k < 40; k++) cycle(1'b0, '0);
    tests_run++;
    if (max_pend != MAXO) begin
      failed++; $display("FAIL lat_pending: got max %0d expected %0d", max_pend, MAXO);
    end
    tests_run++;
    if (deliv.size() < 10) begin
      failed++; $display("FAIL lat_progress: got %0d deliveries expected >= 10", deliv.size());
    end
    foreach (deliv[i]) begin
      tests_run++;
      if (deliv[i] !== 32'(i) * 32'd4) begin
        failed++; $display("FAIL lat_pc[%0d]: got %h expected %h", i, deliv[i], 32'(i) * 32'd4);
      end
    end
  endtask

  task automatic test_redirect();
    bit hit = 1'b0;
    do_reset();
    gnt_pct = 100; rdy_pct = 0; lat_min = 3; lat_max = 3;
    for (int unsigned k = 0; k < 30 && !hit; k++) begin
      if (m_infl.size() == 2 && m_q.size() >= 1) hit = 1'b1;
      else cycle(1'b0, '0);
    end
    tests_run++;
    if (!hit) begin
      failed++; $display("FAIL redir_setup: got no 2-outstanding point expected one within 30 cycles");
    end
    rdy_pct = 100;
    cycle(1'b1, 32'h0000_0100);
    deliv.delete();
    cycle(1'b0, '0);
    tests_run++;
    if (inst_valid !== 1'b0) begin
      failed++; $display("FAIL redir_flush: got inst_valid=%b expected 0", inst_valid);
    end
    for (int unsigned k = 0; k < 20; k++) cycle(1'b0, '0);
    tests_run++;
    if (deliv.size() < 2 || deliv[0] !== 32'h100 || deliv[1] !== 32'h104) begin
      failed++;
      $display("FAIL redir_first: got %0d words first=%h expected first 00000100 then 00000104",
               deliv.size(), (deliv.size() > 0) ? deliv[0] : 32'hx);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1;
    cycle(1'b0, '0);
    cycle(1'b1, 32'hFFFF_FFFC);
    grants.delete();
    for (int unsigned k = 0; k < 6; k++) cycle(1'b0, '0);
    tests_run++;
    if (grants.size() < 2 || grants[0] !== 32'hFFFF_FFFC || grants[1] !== 32'h0) begin
      failed++;
      $display("FAIL wrap_addr: got %0d grants first=%h expected FFFFFFFC then 00000000",
               grants.size(), (grants.size() > 0) ? grants[0] : 32'hx);
    end
    cycle(1'b1, 32'h0000_0203);
    grants.delete();
    cycle(1'b0, '0);
    tests_run++;
    if (imem_addr !== 32'h200 || imem_req !== 1'b1) begin
      failed++; $display("FAIL align_addr: got req=%b addr=%h expected 1 00000200", imem_req, imem_addr);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    gnt_pct = 100; rdy_pct = 0; lat_min = 3; lat_max = 3;
    for (int unsigned k = 0; k < 5; k++) cycle(1'b0, '0);
    #2;
    rst = 1'b1; redirect_valid = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; inst_ready = 1'b0;
    #1;
    tests_run++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0 || imem_addr !== 32'h0 ||
        inst_encoding !== 32'h0 || inst_pc !== 32'h0) begin
      failed++;
      $display("FAIL async_reset: got req=%b valid=%b addr=%h enc=%h pc=%h expected 0,0,0,0,0",
               imem_req, inst_valid, imem_addr, inst_encoding, inst_pc);
    end
    @(negedge clk); @(negedge clk);
    clear_env();
    rst = 1'b0;
    rdy_pct = 100;
    for (int unsigned k = 0; k < 4; k++) cycle(1'b0, '0);
    tests_run++;
    if (grants.size() == 0 || grants[0] !== 32'h0) begin
      failed++; $display("FAIL post_reset_addr: got %h expected 00000000",
                         (grants.size() > 0) ? grants[0] : 32'hx);
    end
  endtask

  task automatic test_random();
    bit r;
    do_reset();
    gnt_pct = 60; rdy_pct = 70; lat_min = 1; lat_max = 4;
    for (int unsigned k = 0; k < 1500; k++) begin
      r = ($urandom_range(0, 99) < 3);
      cycle(r, $urandom);
    end
    tests_run++;
    if (max_pend > MAXO) begin
      failed++; $display("FAIL rand_pending: got max %0d expected <= %0d", max_pend, MAXO);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_latency();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
